rk_spi_port: RTL and testbench

//  CPU-mapped SPI master for SD card and other serial peripherals, on the 0xA000 PPA2 slot of the Radio-86RK top.
//  - Compat mode: bit-bang, matches the existing SD port; BIOS drivers run unmodified.
//  - Byte mode: hardware 8-bit SPI mode-0 engine with programmable SCLK divider, NCS chip selects and done IRQ.

---
 rtl/rk_spi_port_pkg.sv | 25 ++
 rtl/rk_spi_port_engine.sv | 123 ++++++++++++
 rtl/rk_spi_port.sv | 143 ++++++++++++++
 tb/tb_rk_spi_port.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rk_spi_port_pkg.sv
// Shared register map, bit positions and engine state type for the RK SPI port.
// Imported by the top and by the byte engine.
package rk_spi_port_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_DATA = 2'd1;
  localparam logic [1:0] REG_DIV  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_IRQ_EN = 6;
  localparam int CTRL_MODE   = 7;

  localparam int DIV_RST_DEFAULT = 62;

  typedef enum logic {
    ENG_IDLE = 1'b0,
    ENG_XFER = 1'b1
  } eng_state_t;

  function automatic logic [7:0] stat_word(input logic busy, input logic done,
                                           input logic ovr, input logic mode);
    return {busy, done, ovr, mode, 4'b0000};
  endfunction

endpackage

// File: rtl/rk_spi_port_engine.sv
// Byte-wide SPI mode-0 engine: half-period divider, 16-toggle bit counter,
// MSB-first tx/rx shifters, busy and sticky done flag.
module rk_spi_port_engine
  import rk_spi_port_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk50,
  input  logic             reset,
  input  logic             i_start,
  input  logic [DIV_W-1:0] i_div,
  input  logic [7:0]       i_tx,
  input  logic             i_miso,
  input  logic             i_done_clr,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_sclk,
  output logic             o_mosi,
  output logic [7:0]       o_rx_buf
);

  eng_state_t       r_state, w_state_next;
  logic [DIV_W-1:0] r_div, w_div_next;
  logic [DIV_W-1:0] r_cnt, w_cnt_next;
  logic [3:0]       r_tcnt, w_tcnt_next;
  logic             r_sclk, w_sclk_next;
  logic             r_mosi, w_mosi_next;
  logic [7:0]       r_tx_sh, w_tx_sh_next;
  logic [7:0]       r_rx_sh, w_rx_sh_next;
  logic [7:0]       r_rx_buf, w_rx_buf_next;
  logic             r_done, w_done_next;
  logic             w_done_set;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_state  <= ENG_IDLE;
      r_div    <= '0;
      r_cnt    <= '0;
      r_tcnt   <= '0;
      r_sclk   <= 1'b0;
      r_mosi   <= 1'b1;
      r_tx_sh  <= '0;
      r_rx_sh  <= '0;
      r_rx_buf <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_div    <= w_div_next;
      r_cnt    <= w_cnt_next;
      r_tcnt   <= w_tcnt_next;
      r_sclk   <= w_sclk_next;
      r_mosi   <= w_mosi_next;
      r_tx_sh  <= w_tx_sh_next;
      r_rx_sh  <= w_rx_sh_next;
      r_rx_buf <= w_rx_buf_next;
      r_done   <= w_done_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_div_next    = r_div;
    w_cnt_next    = r_cnt;
    w_tcnt_next   = r_tcnt;
    w_sclk_next   = r_sclk;
    w_mosi_next   = r_mosi;
    w_tx_sh_next  = r_tx_sh;
    w_rx_sh_next  = r_rx_sh;
    w_rx_buf_next = r_rx_buf;
    w_done_set    = 1'b0;
    case (r_state)
      ENG_IDLE: begin
        if (i_start) begin
          w_state_next = ENG_XFER;
          w_div_next   = i_div;
          w_cnt_next   = '0;
          w_tcnt_next  = '0;
          w_sclk_next  = 1'b0;
          w_mosi_next  = i_tx[7];
          w_tx_sh_next = i_tx;
        end
      end
      ENG_XFER: begin
        if (r_cnt == r_div) begin
          w_cnt_next  = '0;
          w_tcnt_next = r_tcnt + 4'd1;
          if (!r_sclk) begin
            w_sclk_next  = 1'b1;
            w_rx_sh_next = {r_rx_sh[6:0], i_miso};
          end else if (r_tcnt == 4'd15) begin
            // Final falling edge: byte complete, line returns to idle levels.
            w_state_next  = ENG_IDLE;
            w_sclk_next   = 1'b0;
            w_mosi_next   = 1'b1;
            w_rx_buf_next = r_rx_sh;
            w_done_set    = 1'b1;
          end else begin
            w_sclk_next  = 1'b0;
            w_tx_sh_next = {r_tx_sh[6:0], 1'b0};
            w_mosi_next  = r_tx_sh[6];
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_state_next = ENG_IDLE;
    endcase
    // Completion beats a simultaneous read-clear.
    if (w_done_set)
      w_done_next = 1'b1;
    else if (i_done_clr)
      w_done_next = 1'b0;
    else
      w_done_next = r_done;
  end

  assign o_busy   = (r_state == ENG_XFER);
  assign o_done   = r_done;
  assign o_sclk   = r_sclk;
  assign o_mosi   = r_mosi;
  assign o_rx_buf = r_rx_buf;

endmodule

// File: rtl/rk_spi_port.sv
// CPU-mapped SPI master: bit-bang compat path plus hardware byte engine,
// register file, chip selects and done interrupt.
module rk_spi_port
  import rk_spi_port_pkg::*;
#(
  parameter int NCS     = 1,
  parameter int DIV_W   = 8,
  parameter int DIV_RST = DIV_RST_DEFAULT
) (
  input  logic           clk50,
  input  logic           reset,
  input  logic           sel,
  input  logic [1:0]     addr,
  input  logic           we_n,
  input  logic           rd,
  input  logic [7:0]     idata,
  output logic [7:0]     odata,
  output logic           spi_sclk,
  output logic           spi_mosi,
  input  logic           spi_miso,
  output logic [NCS-1:0] spi_cs_n,
  output logic           busy,
  output logic           irq
);

  logic             r_wr_q;
  logic             r_rd_q;
  logic [NCS-1:0]   r_cs;
  logic             r_irq_en;
  logic             r_mode;
  logic [DIV_W-1:0] r_div;
  logic             r_ovr;
  logic [6:0]       r_sh;
  logic             r_c_sclk;
  logic             r_c_mosi;

  logic       w_wr, w_wr_start, w_rd, w_rd_rise;
  logic       w_data_start, w_eng_start, w_ovr_set, w_done_clr, w_mode_sw;
  logic       w_busy, w_done, w_e_sclk, w_e_mosi;
  logic [7:0] w_rx_buf, w_ctrl_rd;

  assign w_wr       = sel & ~we_n;
  assign w_wr_start = w_wr & ~r_wr_q;
  assign w_rd       = sel & rd;
  assign w_rd_rise  = w_rd & ~r_rd_q;

  assign w_data_start = w_wr_start & (addr == REG_DATA) & r_mode;
  assign w_eng_start  = w_data_start & ~w_busy;
  assign w_ovr_set    = w_data_start & w_busy;
  assign w_done_clr   = w_rd_rise & (addr == REG_DATA) & r_mode;
  assign w_mode_sw    = w_wr & (addr == REG_CTRL) & ~w_busy & (idata[CTRL_MODE] != r_mode);

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_wr_q   <= 1'b0;
      r_rd_q   <= 1'b0;
      r_cs     <= '0;
      r_irq_en <= 1'b0;
      r_mode   <= 1'b0;
      r_div    <= DIV_W'(DIV_RST);
      r_ovr    <= 1'b0;
    end else begin
      r_wr_q <= w_wr;
      r_rd_q <= w_rd;
      if (w_wr && addr == REG_CTRL) begin
        r_cs     <= idata[NCS-1:0];
        r_irq_en <= idata[CTRL_IRQ_EN];
        // Mode is frozen while a byte is on the wire.
        if (!w_busy)
          r_mode <= idata[CTRL_MODE];
      end
      if (w_wr && addr == REG_DIV)
        r_div <= DIV_W'(idata);
      if (w_ovr_set)
        r_ovr <= 1'b1;
      else if (w_wr && addr == REG_STAT)
        r_ovr <= 1'b0;
    end
  end

  // Compat bit-bang path is level-driven; a write beats a concurrent read.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      r_sh     <= '0;
      r_c_sclk <= 1'b0;
      r_c_mosi <= 1'b1;
    end else if (w_mode_sw) begin
      r_c_sclk <= 1'b0;
      r_c_mosi <= 1'b1;
    end else if (!r_mode) begin
      if (w_wr && addr == REG_DATA) begin
        if (r_c_sclk)
          r_sh <= {r_sh[5:0], spi_miso};
        r_c_mosi <= idata[7];
        r_c_sclk <= 1'b0;
      end else if (w_rd && !w_wr) begin
        r_c_sclk <= 1'b1;
      end
    end
  end

  rk_spi_port_engine #(
    .DIV_W (DIV_W)
  ) u_engine (
    .clk50      (clk50),
    .reset      (reset),
    .i_start    (w_eng_start),
    .i_div      (r_div),
    .i_tx       (idata),
    .i_miso     (spi_miso),
    .i_done_clr (w_done_clr),
    .o_busy     (w_busy),
    .o_done     (w_done),
    .o_sclk     (w_e_sclk),
    .o_mosi     (w_e_mosi),
    .o_rx_buf   (w_rx_buf)
  );

  always_comb begin
    w_ctrl_rd              = '0;
    w_ctrl_rd[NCS-1:0]     = r_cs;
    w_ctrl_rd[CTRL_IRQ_EN] = r_irq_en;
    w_ctrl_rd[CTRL_MODE]   = r_mode;
  end

  always_comb begin
    odata = '0;
    case (addr)
      REG_CTRL: odata = w_ctrl_rd;
      REG_DATA: odata = r_mode ? w_rx_buf : {r_sh, spi_miso};
      REG_DIV:  odata = 8'(r_div);
      REG_STAT: odata = stat_word(w_busy, w_done, r_ovr, r_mode);
      default:  odata = '0;
    endcase
  end

  assign spi_sclk = r_mode ? w_e_sclk : r_c_sclk;
  assign spi_mosi = r_mode ? w_e_mosi : r_c_mosi;
  assign spi_cs_n = ~r_cs;
  assign busy     = w_busy;
  assign irq      = w_done & r_irq_en;

endmodule

// File: tb/tb_rk_spi_port.sv
// Self-checking bench for rk_spi_port: SPI slave model plus a scoreboard of
// expected byte transfers, register and pin checks around each one.
module tb_rk_spi_port;
  import rk_spi_port_pkg::*;

  logic       clk50 = 1'b0;
  logic       reset;
  logic       sel, we_n, rd;
  logic [1:0] addr;
  logic [7:0] idata, odata;
  logic       spi_sclk, spi_mosi, spi_miso;
  logic [1:0] spi_cs_n;
  logic       busy, irq;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] rx;
    int         busy_cyc;
  } xfer_t;
  xfer_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic       slave_en = 1'b0;
  logic       miso_drv = 1'b0;
  logic [7:0] slave_sh = 8'h00;
  logic [7:0] mosi_cap = 8'h00;
  int         rise_cnt = 0;
  int         busy_cnt = 0;
  int         cs_bad = 0;
  int         irq_early = 0;
  logic       cs_chk_en = 1'b0;
  logic [1:0] cs_exp = 2'b11;
  logic       exp_irq = 1'b0;
  logic       exp_ovr = 1'b0;
  logic [7:0] rd_val;

  assign spi_miso = slave_en ? slave_sh[7] : miso_drv;

  always #10 clk50 = ~clk50;

  rk_spi_port #(
    .NCS     (2),
    .DIV_W   (8),
    .DIV_RST (62)
  ) dut (
    .clk50    (clk50),
    .reset    (reset),
    .sel      (sel),
    .addr     (addr),
    .we_n     (we_n),
    .rd       (rd),
    .idata    (idata),
    .odata    (odata),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n),
    .busy     (busy),
    .irq      (irq)
  );

  // SPI slave: capture mosi on rising sclk, advance miso after falling sclk.
  always @(posedge spi_sclk) begin
    if (slave_en) begin
      mosi_cap = {mosi_cap[6:0], spi_mosi};
      rise_cnt++;
    end
  end

  always @(negedge spi_sclk) begin
    if (slave_en)
      slave_sh = {slave_sh[6:0], 1'b0};
  end

  always @(negedge clk50) begin
    if (busy) begin
      busy_cnt++;
      if (cs_chk_en && spi_cs_n !== cs_exp)
        cs_bad++;
      if (irq)
        irq_early++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] d, input int hold);
    @(negedge clk50);
    sel   = 1'b1;
    addr  = a;
    idata = d;
    we_n  = 1'b0;
    repeat (hold) @(negedge clk50);
    we_n = 1'b1;
    sel  = 1'b0;
  endtask

  task automatic cpu_read(input logic [1:0] a, output logic [7:0] d);
    @(negedge clk50);
    sel  = 1'b1;
    addr = a;
    rd   = 1'b1;
    #1 d = odata;
    @(negedge clk50);
    rd  = 1'b0;
    sel = 1'b0;
  endtask

  task automatic start_xfer(input logic [7:0] tx, input logic [7:0] slv,
                            input int busy_cyc, input int hold);
    xfer_t e;
    e.tx       = tx;
    e.rx       = slv;
    e.busy_cyc = busy_cyc;
    sb.push_back(e);
    slave_sh  = slv;
    mosi_cap  = 8'h00;
    rise_cnt  = 0;
    busy_cnt  = 0;
    irq_early = 0;
    slave_en  = 1'b1;
    cpu_write(REG_DATA, tx, hold);
    if (hold == 1) begin
      check_eq("start_busy", 32'(busy), 32'd1);
      check_eq("start_sclk", 32'(spi_sclk), 32'd0);
      check_eq("start_mosi", 32'(spi_mosi), 32'(tx[7]));
    end
  endtask

  task automatic finish_xfer();
    xfer_t e;
    logic  seen;
    seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk50);
    end
    check_eq("busy_fall_seen", 32'(seen), 32'd1);
    check_eq("irq_at_done", 32'(irq), 32'(exp_irq));
    check_eq("idle_sclk", 32'(spi_sclk), 32'd0);
    check_eq("idle_mosi", 32'(spi_mosi), 32'd1);
    check_eq("irq_early", 32'(irq_early), 32'd0);
    check_eq("sb_pending", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check_eq("mosi_bits", 32'(mosi_cap), 32'(e.tx));
      check_eq("sclk_rises", 32'(rise_cnt), 32'd8);
      check_eq("busy_cycles", 32'(busy_cnt), 32'(e.busy_cyc));
      cpu_read(REG_STAT, rd_val);
      check_eq("stat_done", 32'(rd_val), 32'({1'b0, 1'b1, exp_ovr, 1'b1, 4'b0000}));
      cpu_read(REG_DATA, rd_val);
      check_eq("rx_data", 32'(rd_val), 32'(e.rx));
      check_eq("irq_cleared", 32'(irq), 32'd0);
      cpu_read(REG_STAT, rd_val);
      check_eq("stat_cleared", 32'(rd_val), 32'({1'b0, 1'b0, exp_ovr, 1'b1, 4'b0000}));
      $display("xfer tx=%02h rx=%02h busy_cycles=%0d", e.tx, e.rx, busy_cnt);
    end
    slave_en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    sel   = 1'b0;
    we_n  = 1'b1;
    rd    = 1'b0;
    addr  = 2'd0;
    idata = 8'h00;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk50);
    check_eq("rst_cs_n", 32'(spi_cs_n), 32'h3);
    check_eq("rst_sclk", 32'(spi_sclk), 32'd0);
    check_eq("rst_mosi", 32'(spi_mosi), 32'd1);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    reset = 1'b0;
    cpu_read(REG_STAT, rd_val);
    check_eq("rst_stat", 32'(rd_val), 32'h00);
    cpu_read(REG_DIV, rd_val);
    check_eq("rst_div", 32'(rd_val), 32'd62);

    // Compat bit-bang sequence.
    cpu_write(REG_DATA, 8'h80, 1);
    check_eq("cmp_mosi1", 32'(spi_mosi), 32'd1);
    check_eq("cmp_sclk0", 32'(spi_sclk), 32'd0);
    cpu_read(REG_STAT, rd_val);
    check_eq("cmp_sclk1", 32'(spi_sclk), 32'd1);
    miso_drv = 1'b1;
    cpu_write(REG_DATA, 8'h00, 1);
    check_eq("cmp_mosi0", 32'(spi_mosi), 32'd0);
    check_eq("cmp_sclk0b", 32'(spi_sclk), 32'd0);
    cpu_read(REG_DATA, rd_val);
    check_eq("cmp_data", 32'(rd_val), 32'h03);
    miso_drv = 1'b0;

    // Byte mode, DIV=1.
    cpu_write(REG_CTRL, 8'h81, 1);
    cpu_write(REG_DIV, 8'd1, 1);
    exp_irq = 1'b0;
    exp_ovr = 1'b0;
    start_xfer(8'hA5, 8'h3C, 32, 1);
    finish_xfer();

    // Overrun: second start three cycles after the first.
    start_xfer(8'h96, 8'h69, 32, 1);
    @(negedge clk50);
    cpu_write(REG_DATA, 8'hFF, 1);
    exp_ovr = 1'b1;
    finish_xfer();
    cpu_write(REG_STAT, 8'h00, 1);
    exp_ovr = 1'b0;
    cpu_read(REG_STAT, rd_val);
    check_eq("ovr_cleared", 32'(rd_val), 32'h10);

    // IRQ and chip select; CTRL write mid-transfer must not drop mode.
    cpu_write(REG_CTRL, 8'hC2, 1);
    cs_exp    = 2'b01;
    cs_bad    = 0;
    cs_chk_en = 1'b1;
    exp_irq   = 1'b1;
    start_xfer(8'hE7, 8'h18, 32, 1);
    cpu_write(REG_CTRL, 8'h42, 1);
    finish_xfer();
    cs_chk_en = 1'b0;
    check_eq("cs_held", 32'(cs_bad), 32'd0);
    check_eq("cs_pins", 32'(spi_cs_n), 32'h1);
    cpu_read(REG_CTRL, rd_val);
    check_eq("ctrl_mode_held", 32'(rd_val), 32'hC2);
    cpu_write(REG_CTRL, 8'h81, 1);
    exp_irq = 1'b0;

    // Long write strobe gives exactly one transfer.
    start_xfer(8'hC3, 8'h5A, 32, 20);
    finish_xfer();
    busy_cnt = 0;
    repeat (40) @(negedge clk50);
    check_eq("no_second_xfer", 32'(busy_cnt), 32'd0);

    // DIV=0, and a DIV write during a transfer applies to the next one.
    cpu_write(REG_DIV, 8'd0, 1);
    start_xfer(8'h5A, 8'hC3, 16, 1);
    cpu_write(REG_DIV, 8'd3, 1);
    finish_xfer();
    cpu_read(REG_DIV, rd_val);
    check_eq("div_readback", 32'(rd_val), 32'd3);
    start_xfer(8'h0F, 8'hF0, 64, 1);
    finish_xfer();

    // Back to compat: idle line levels, shift register kept.
    cpu_write(REG_CTRL, 8'h01, 1);
    check_eq("sw_sclk", 32'(spi_sclk), 32'd0);
    check_eq("sw_mosi", 32'(spi_mosi), 32'd1);
    cpu_read(REG_DATA, rd_val);
    check_eq("sw_sh_kept", 32'(rd_val), 32'h02);

    // Reset in the middle of a byte.
    cpu_write(REG_CTRL, 8'h81, 1);
    cpu_write(REG_DIV, 8'd1, 1);
    slave_sh = 8'hFF;
    slave_en = 1'b1;
    cpu_write(REG_DATA, 8'hA5, 1);
    repeat (10) @(negedge clk50);
    #3 reset = 1'b1;
    #1;
    check_eq("mid_rst_cs_n", 32'(spi_cs_n), 32'h3);
    check_eq("mid_rst_sclk", 32'(spi_sclk), 32'd0);
    check_eq("mid_rst_mosi", 32'(spi_mosi), 32'd1);
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    slave_en = 1'b0;
    @(negedge clk50);
    reset = 1'b0;
    cpu_read(REG_STAT, rd_val);
    check_eq("mid_rst_stat", 32'(rd_val), 32'h00);
    cpu_read(REG_DIV, rd_val);
    check_eq("mid_rst_div", 32'(rd_val), 32'd62);
    cpu_read(REG_CTRL, rd_val);
    check_eq("mid_rst_ctrl", 32'(rd_val), 32'h00);
    cpu_write(REG_CTRL, 8'h80, 1);
    cpu_read(REG_DATA, rd_val);
    check_eq("mid_rst_rxbuf", 32'(rd_val), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
